column_rasterizer: RTL and testbench

Consumes one per-column DDA result from the DDA-out FIFO and expands it into SCREEN_HEIGHT pixel writes (ceiling, wall slice, floor) for the frame buffer's ray-write port. It sits between the DDA-out FIFO (AXI-stream-style receiver side) and `frame_buffer`. It emits one RGB565 pixel per cycle and flags the final pixel of a frame.

---
 rtl/column_rasterizer.sv | 176 +++++++++++++++++
 tb/tb_column_rasterizer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/column_rasterizer.sv
// column_rasterizer: expands one DDA column record into SCREEN_HEIGHT
// RGB565 pixel writes (ceiling, wall slice, floor), one pixel per cycle.
module column_rasterizer #(
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 240,
  parameter logic [15:0] CEIL_COLOR    = 16'h2104,
  parameter logic [15:0] FLOOR_COLOR   = 16'h4208
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        dda_fifo_tvalid_in,
  input  logic [37:0] dda_fifo_tdata_in,
  input  logic        dda_fifo_tlast_in,
  output logic        rasterizer_tready_out,
  output logic [16:0] ray_address_out,
  output logic [15:0] ray_pixel_out,
  output logic        ray_valid_out,
  output logic        ray_last_pixel_out
);

  localparam logic [8:0]  HEIGHT_9   = 9'(SCREEN_HEIGHT);
  localparam logic [8:0]  LAST_ROW_9 = 9'(SCREEN_HEIGHT - 1);
  localparam logic [16:0] WIDTH_17   = 17'(SCREEN_WIDTH);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t state;

  // First wall row; tall slices clamp to the top of the screen.
  function automatic logic [8:0] draw_start(input logic [7:0] lh);
    logic [8:0] lh9;
    lh9 = {1'b0, lh};
    if (lh9 >= HEIGHT_9) return 9'd0;
    return (HEIGHT_9 - lh9) >> 1;
  endfunction

  // Last wall row; lineHeight=0 wraps to drawStart-1 so no row is wall.
  function automatic logic [8:0] draw_end(input logic [7:0] lh);
    logic [8:0] lh9;
    lh9 = {1'b0, lh};
    if (lh9 >= HEIGHT_9) return LAST_ROW_9;
    return draw_start(lh) + lh9 - 9'd1;
  endfunction

  // Halve each RGB565 channel; the mask stops bits leaking between fields.
  function automatic logic [15:0] shade_half(input logic [15:0] c);
    return (c >> 1) & 16'h7BEF;
  endfunction

  function automatic logic [15:0] wall_color(input logic [3:0] map, input logic y_side);
    logic [15:0] c;
    case (map)
      4'd0:    c = 16'hF81F;
      4'd1:    c = 16'hF800;
      4'd2:    c = 16'h07E0;
      4'd3:    c = 16'h001F;
      4'd4:    c = 16'hFFFF;
      default: c = 16'hFFE0;
    endcase
    return y_side ? shade_half(c) : c;
  endfunction

  // Latched column record and sweep position
  logic [8:0]  hc_p0;
  logic [8:0]  ds_p0;
  logic [8:0]  de_p0;
  logic [3:0]  map_p0;
  logic        wt_p0;
  logic        last_p0;
  logic [15:0] wallx_unused_p0;
  logic [8:0]  y_p0;
  logic [16:0] addr_p0;

  logic        accept;
  logic [8:0]  src_hc, src_ds, src_de, nxt_y;
  logic [3:0]  src_map;
  logic        src_wt, src_last;
  logic [16:0] nxt_addr;
  logic [15:0] nxt_pix;
  logic        nxt_valid, nxt_last;

  assign accept = dda_fifo_tvalid_in && rasterizer_tready_out;

  // Next row's address/pixel: from the incoming record on accept, else from the latched one.
  always_comb begin
    if (state == IDLE) begin
      src_hc   = dda_fifo_tdata_in[37:29];
      src_ds   = draw_start(dda_fifo_tdata_in[28:21]);
      src_de   = draw_end(dda_fifo_tdata_in[28:21]);
      src_wt   = dda_fifo_tdata_in[20];
      src_map  = dda_fifo_tdata_in[19:16];
      src_last = dda_fifo_tlast_in;
      nxt_y    = 9'd0;
      nxt_addr = {8'd0, dda_fifo_tdata_in[37:29]};
    end else begin
      src_hc   = hc_p0;
      src_ds   = ds_p0;
      src_de   = de_p0;
      src_wt   = wt_p0;
      src_map  = map_p0;
      src_last = last_p0;
      nxt_y    = y_p0 + 9'd1;
      nxt_addr = addr_p0 + WIDTH_17;
    end
    if (nxt_y < src_ds)      nxt_pix = CEIL_COLOR;
    else if (nxt_y > src_de) nxt_pix = FLOOR_COLOR;
    else                     nxt_pix = wall_color(src_map, src_wt);
    nxt_valid = ({8'd0, src_hc} < WIDTH_17);
    nxt_last  = src_last && (nxt_y == LAST_ROW_9);
  end

  // Record latch and running row/address; no reset needed on datapath state.
  always_ff @(posedge pixel_clk_in) begin
    if (accept) begin
      hc_p0           <= src_hc;
      ds_p0           <= src_ds;
      de_p0           <= src_de;
      wt_p0           <= src_wt;
      map_p0          <= src_map;
      last_p0         <= src_last;
      wallx_unused_p0 <= dda_fifo_tdata_in[15:0];
      y_p0            <= nxt_y;
      addr_p0         <= nxt_addr;
    end else if (state == DRAW) begin
      y_p0    <= nxt_y;
      addr_p0 <= nxt_addr;
    end
  end

  // FSM and registered outputs; address/pixel hold whenever no write is issued.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state                 <= IDLE;
      rasterizer_tready_out <= 1'b1;
      ray_valid_out         <= 1'b0;
      ray_last_pixel_out    <= 1'b0;
      ray_address_out       <= '0;
      ray_pixel_out         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state                 <= DRAW;
            rasterizer_tready_out <= 1'b0;
            ray_valid_out         <= nxt_valid;
            ray_last_pixel_out    <= nxt_last;
            if (nxt_valid) begin
              ray_address_out <= nxt_addr;
              ray_pixel_out   <= nxt_pix;
            end
          end else begin
            ray_valid_out      <= 1'b0;
            ray_last_pixel_out <= 1'b0;
          end
        end
        DRAW: begin
          if (y_p0 == LAST_ROW_9) begin
            state                 <= IDLE;
            rasterizer_tready_out <= 1'b1;
            ray_valid_out         <= 1'b0;
            ray_last_pixel_out    <= 1'b0;
          end else begin
            ray_valid_out      <= nxt_valid;
            ray_last_pixel_out <= nxt_last;
            if (nxt_valid) begin
              ray_address_out <= nxt_addr;
              ray_pixel_out   <= nxt_pix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_rasterizer.sv
// Bench for column_rasterizer: directed and randomized column records
// compared cycle by cycle against a row-indexed reference model.
module tb_column_rasterizer;

  localparam int W = 320;
  localparam int H = 240;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic [37:0] tdata;
  logic        tlast;
  logic        rasterizer_tready_out;
  logic [16:0] ray_address_out;
  logic [15:0] ray_pixel_out;
  logic        ray_valid_out;
  logic        ray_last_pixel_out;

  always #5 clk = ~clk;

  column_rasterizer dut (
    .pixel_clk_in          (clk),
    .rst_in                (rst),
    .dda_fifo_tvalid_in    (tvalid),
    .dda_fifo_tdata_in     (tdata),
    .dda_fifo_tlast_in     (tlast),
    .rasterizer_tready_out (rasterizer_tready_out),
    .ray_address_out       (ray_address_out),
    .ray_pixel_out         (ray_pixel_out),
    .ray_valid_out         (ray_valid_out),
    .ray_last_pixel_out    (ray_last_pixel_out)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state: which row of which record is on the outputs
  bit m_busy = 1'b0;
  int m_row, m_hc, m_lh, m_map;
  bit m_wt, m_last;

  // observations
  int          last_addr_seen, n_valid_seen, n_last, last_pulse_cyc, last_pulse_addr, n_blue;
  logic [15:0] last_pix_seen;

  function automatic logic [15:0] ref_pixel(input int y, input int lh, input int map, input bit wt);
    int ds, de;
    logic [15:0] c;
    if (lh >= H) begin ds = 0; de = H - 1; end
    else begin ds = (H - lh) / 2; de = ds + lh - 1; end
    if (y < ds) return 16'h2104;
    if (y > de) return 16'h4208;
    case (map)
      0:       c = 16'hF81F;
      1:       c = 16'hF800;
      2:       c = 16'h07E0;
      3:       c = 16'h001F;
      4:       c = 16'hFFFF;
      default: c = 16'hFFE0;
    endcase
    if (wt) c = (c >> 1) & 16'h7BEF;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    bit exp_valid;
    @(posedge clk);
    cyc++;
    if (rst) m_busy = 1'b0;
    else if (!m_busy) begin
      if (tvalid) begin
        m_busy = 1'b1;
        m_row  = 0;
        m_hc   = int'(tdata[37:29]);
        m_lh   = int'(tdata[28:21]);
        m_wt   = tdata[20];
        m_map  = int'(tdata[19:16]);
        m_last = tlast;
      end
    end else if (m_row == H - 1) m_busy = 1'b0;
    else m_row++;
    #1;
    exp_valid = m_busy && (m_hc < W);
    check("tready", 32'(rasterizer_tready_out), 32'(!m_busy));
    check("valid", 32'(ray_valid_out), 32'(exp_valid));
    check("last", 32'(ray_last_pixel_out), 32'(m_busy && m_last && (m_row == H - 1)));
    if (exp_valid) begin
      check("addr", 32'(ray_address_out), 32'(m_row * W + m_hc));
      check("pixel", 32'(ray_pixel_out), 32'(ref_pixel(m_row, m_lh, m_map, m_wt)));
    end
    if (ray_valid_out) begin
      last_addr_seen = int'(ray_address_out);
      last_pix_seen  = ray_pixel_out;
      n_valid_seen++;
      if (ray_pixel_out == 16'h001F) n_blue++;
    end
    if (ray_last_pixel_out) begin
      n_last++;
      last_pulse_cyc  = cyc;
      last_pulse_addr = int'(ray_address_out);
    end
  endtask

  task automatic clear_obs();
    n_valid_seen = 0; n_last = 0; n_blue = 0;
    last_addr_seen = -1; last_pulse_cyc = -1; last_pulse_addr = -1;
  endtask

  // present a record and tick until the DUT takes it; acc = accepting cycle
  task automatic send(input int hc, input int lh, input bit wt, input int map,
                      input bit last, input bit hold, output int acc);
    bit rdy;
    int k;
    tdata  = {9'(hc), 8'(lh), wt, 4'(map), 16'($urandom)};
    tlast  = last;
    tvalid = 1'b1;
    k = 0;
    do begin
      rdy = rasterizer_tready_out;
      tick();
      k++;
    end while (!rdy && k < 600);
    check("accept", 32'(rdy), 32'd1);
    acc = cyc - 1;
    if (!hold) tvalid = 1'b0;
  endtask

  task automatic drain(input int acc);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!rasterizer_tready_out && k < 300);
    check("ready_back", 32'(cyc - acc), 32'd241);
  endtask

  initial begin
    int acc, acc_a, acc_b, hc, lh, map, gap;
    bit wt, last;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
    clear_obs();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_addr", 32'(ray_address_out), 32'd0);
    check("reset_pixel", 32'(ray_pixel_out), 32'd0);

    // empty FIFO: nothing happens
    repeat (8) tick();

    clear_obs();
    send(5, 100, 1'b0, 1, 1'b0, 1'b0, acc);
    drain(acc);
    check("c1_last_addr", 32'(last_addr_seen), 32'd76485);
    check("c1_nvalid", 32'(n_valid_seen), 32'd240);

    clear_obs();
    send(319, 255, 1'b1, 2, 1'b0, 1'b0, acc);
    drain(acc);
    check("c2_last_addr", 32'(last_addr_seen), 32'd76799);
    check("c2_last_pix", 32'(last_pix_seen), 32'h03E0);

    clear_obs();
    send(10, 0, 1'b0, 3, 1'b0, 1'b0, acc);
    drain(acc);
    check("c3_no_wall", 32'(n_blue), 32'd0);
    check("c3_nvalid", 32'(n_valid_seen), 32'd240);

    clear_obs();
    send(7, 50, 1'b0, 4, 1'b0, 1'b1, acc_a);
    send(33, 120, 1'b1, 9, 1'b1, 1'b0, acc_b);
    drain(acc_b);
    check("b2b_gap", 32'(acc_b - acc_a), 32'd241);
    check("b2b_last_cnt", 32'(n_last), 32'd1);
    check("b2b_last_addr", 32'(last_pulse_addr), 32'(76800 - 320 + 33));
    check("b2b_last_cyc", 32'(last_pulse_cyc - acc_b), 32'd240);

    clear_obs();
    send(400, 80, 1'b0, 1, 1'b1, 1'b0, acc);
    drain(acc);
    check("oob_nvalid", 32'(n_valid_seen), 32'd0);
    check("oob_last_cnt", 32'(n_last), 32'd1);
    check("oob_last_cyc", 32'(last_pulse_cyc - acc), 32'd240);

    send(100, 60, 1'b0, 2, 1'b0, 1'b0, acc);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(ray_valid_out), 32'd0);
    check("rst_ready", 32'(rasterizer_tready_out), 32'd1);
    send(200, 30, 1'b1, 4, 1'b1, 1'b0, acc);
    check("rst_row0_addr", 32'(ray_address_out), 32'd200);
    drain(acc);

    for (int i = 0; i < 12; i++) begin
      gap  = $urandom_range(0, 3);
      repeat (gap) tick();
      hc   = ($urandom_range(0, 9) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 319);
      lh   = $urandom_range(0, 255);
      map  = $urandom_range(0, 15);
      wt   = 1'($urandom_range(0, 1));
      last = 1'($urandom_range(0, 1));
      send(hc, lh, wt, map, last, 1'b0, acc);
      drain(acc);
    end

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
